// File: rtl/dm_spi_pkg.sv
// Shared constants and state type for the deformable-mirror SPI array master.
package dm_spi_pkg;

  localparam int unsigned OffCtrl   = 'h000;
  localparam int unsigned OffStatus = 'h004;
  localparam int unsigned OffChMask = 'h008;
  localparam int unsigned OffTxBase = 'h100;
  localparam int unsigned OffRxBase = 'h200;

  localparam int unsigned CtrlGo      = 0;
  localparam int unsigned CtrlLdacEn  = 1;
  localparam int unsigned CtrlPpsTrig = 2;
  localparam int unsigned CtrlDivLsb  = 8;

  localparam int unsigned StatBusy   = 0;
  localparam int unsigned StatDone   = 1;
  localparam int unsigned StatErr    = 2;
  localparam int unsigned StatArmed  = 3;
  localparam int unsigned StatCntLsb = 16;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSetup,
    StShift,
    StHold,
    StLdac
  } spiStateT;

endpackage

// File: rtl/dm_spi_halfbit_timer.sv
// Half-bit timer: one-cycle tick every DIV+1 cycles while running, held at zero otherwise.
module dm_spi_halfbit_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt;

  // Counts up against the live divider so a DIV written together with GO takes effect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = run && (cnt == div);

endmodule

// File: rtl/dm_spi_array_master.sv
// Multi-channel lockstep SPI frame engine with RamBus register access, channel mask,
// programmable SCK divider and optional PPS-synchronous launch with nLDAC strobe.
module dm_spi_array_master
  import dm_spi_pkg::*;
#(
  parameter int unsigned NCHAN      = 6,
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RamBusSel,
  input  logic              RamBusWrnRd,
  input  logic              RamBusLatch,
  input  logic [ADDR_W-1:0] RamBusAddress,
  input  logic [31:0]       RamBusDataIn,
  output logic [31:0]       RamBusDataOut,
  output logic              RamBusAck,
  input  logic              Pps,
  output logic              Sck,
  output logic [NCHAN-1:0]  Mosi,
  input  logic [NCHAN-1:0]  Miso,
  output logic [NCHAN-1:0]  nCs,
  output logic              nLDac
);

  localparam int unsigned HalfLast = 2 * FRAME_BITS - 1;
  localparam int unsigned HcW      = $clog2(2 * FRAME_BITS);

  function automatic logic isReg(input logic [ADDR_W-1:0] a, input int unsigned off);
    logic [ADDR_W-1:0] o;
    o = ADDR_W'(off);
    return a[ADDR_W-1:2] == o[ADDR_W-1:2];
  endfunction

  function automatic logic isBank(input logic [ADDR_W-1:0] a, input int unsigned base);
    logic [ADDR_W-1:0] b;
    b = ADDR_W'(base);
    return (a[ADDR_W-1:6] == b[ADDR_W-1:6]) && (32'(a[5:2]) < NCHAN);
  endfunction

  spiStateT          state;
  logic              sckReg, nLDacReg;
  logic [NCHAN-1:0]  nCsReg, chMask;
  logic [HcW-1:0]    halfCnt;
  logic [7:0]        div;
  logic              ldacEn, ppsTrig, done, err;
  logic [15:0]       frameCnt;
  logic [2:0]        ppsSync;

  logic              accPrev, ackReg, wrEnReg;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       wrData, dataOutReg, rdData;

  logic [FRAME_BITS-1:0] txData  [NCHAN];
  logic [FRAME_BITS-1:0] rxData  [NCHAN];
  logic [FRAME_BITS-1:0] txShift [NCHAN];
  logic [FRAME_BITS-1:0] rxShift [NCHAN];

  logic tick, timerRun, busy, accStart, wrStrobe;
  logic wCtrl, wStatus, wMask, wTx;
  logic abort, goStart, startSetup, busyWriteErr, ppsEdge;
  logic sampleEn, shiftEn, frameEnd;
  logic unusedBits;

  assign busy     = (state != StIdle);
  assign timerRun = (state != StIdle) && (state != StArm);
  assign accStart = RamBusSel & RamBusLatch & ~accPrev;
  assign wrStrobe = ackReg & wrEnReg;
  assign ppsEdge  = ppsSync[1] & ~ppsSync[2];

  assign wCtrl   = isReg(wrAddr, OffCtrl);
  assign wStatus = isReg(wrAddr, OffStatus);
  assign wMask   = isReg(wrAddr, OffChMask);
  assign wTx     = isBank(wrAddr, OffTxBase);

  // A zero CTRL write while armed is the abort, not a protected-register violation.
  assign abort        = wrStrobe & wCtrl & (state == StArm) & (wrData == 32'd0);
  assign goStart      = wrStrobe & wCtrl & ~busy & wrData[CtrlGo];
  assign startSetup   = (goStart & ~wrData[CtrlPpsTrig]) | ((state == StArm) & ppsEdge & ~abort);
  assign busyWriteErr = wrStrobe & busy & ((wCtrl & ~abort) | wMask | wTx);

  // Rising Sck edges: end of SETUP and end of every odd (low) half-period except the last.
  assign sampleEn = tick & ((state == StSetup) |
                    ((state == StShift) & halfCnt[0] & (halfCnt != HcW'(HalfLast))));
  assign shiftEn  = tick & (state == StShift) & ~halfCnt[0];
  assign frameEnd = tick & (state == StHold);

  dm_spi_halfbit_timer uTimer (
    .clk  (clk),
    .rst  (rst),
    .run  (timerRun),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    rdData = '0;
    if (isReg(RamBusAddress, OffCtrl)) begin
      rdData = {16'd0, div, 5'd0, ppsTrig, ldacEn, 1'b0};
    end else if (isReg(RamBusAddress, OffStatus)) begin
      rdData = {frameCnt, 12'd0, (state == StArm), err, done, busy};
    end else if (isReg(RamBusAddress, OffChMask)) begin
      rdData[NCHAN-1:0] = chMask;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (isBank(RamBusAddress, OffTxBase) && RamBusAddress[5:2] == 4'(i)) begin
          rdData[FRAME_BITS-1:0] = txData[i];
        end
        if (isBank(RamBusAddress, OffRxBase) && RamBusAddress[5:2] == 4'(i)) begin
          rdData[FRAME_BITS-1:0] = rxData[i];
        end
      end
    end
  end

  // Writes are applied at the end of the ack cycle so BUSY follows the GO ack by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accPrev    <= 1'b0;
      ackReg     <= 1'b0;
      wrEnReg    <= 1'b0;
      wrAddr     <= '0;
      wrData     <= '0;
      dataOutReg <= '0;
    end else begin
      accPrev    <= RamBusSel & RamBusLatch;
      ackReg     <= accStart;
      dataOutReg <= (accStart & ~RamBusWrnRd) ? rdData : 32'd0;
      if (accStart) begin
        wrEnReg <= RamBusWrnRd;
        wrAddr  <= RamBusAddress;
        wrData  <= RamBusDataIn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      sckReg   <= 1'b0;
      nCsReg   <= '1;
      nLDacReg <= 1'b1;
      halfCnt  <= '0;
      div      <= '0;
      ldacEn   <= 1'b0;
      ppsTrig  <= 1'b0;
      chMask   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      frameCnt <= '0;
      ppsSync  <= '0;
    end else begin
      ppsSync <= {ppsSync[1:0], Pps};

      if (wrStrobe & wCtrl & (~busy | abort)) begin
        div     <= wrData[CtrlDivLsb +: 8];
        ppsTrig <= wrData[CtrlPpsTrig];
        ldacEn  <= wrData[CtrlLdacEn];
      end
      if (wrStrobe & wMask & ~busy) chMask <= wrData[NCHAN-1:0];

      if (busyWriteErr) err <= 1'b1;
      else if (wrStrobe & wStatus & wrData[StatErr]) err <= 1'b0;
      if (wrStrobe & wStatus & wrData[StatDone]) done <= 1'b0;

      if (startSetup) nCsReg <= ~chMask;

      unique case (state)
        StIdle: begin
          if (goStart) state <= wrData[CtrlPpsTrig] ? StArm : StSetup;
        end
        StArm: begin
          if (abort) state <= StIdle;
          else if (ppsEdge) state <= StSetup;
        end
        StSetup: begin
          if (tick) begin
            state   <= StShift;
            sckReg  <= 1'b1;
            halfCnt <= '0;
          end
        end
        StShift: begin
          if (tick) begin
            if (halfCnt == HcW'(HalfLast)) begin
              state <= StHold;
            end else begin
              sckReg  <= ~sckReg;
              halfCnt <= halfCnt + 1'b1;
            end
          end
        end
        StHold: begin
          if (tick) begin
            nCsReg   <= '1;
            done     <= 1'b1;
            frameCnt <= frameCnt + 16'd1;
            if (ldacEn) begin
              state    <= StLdac;
              nLDacReg <= 1'b0;
            end else begin
              state <= StIdle;
            end
          end
        end
        StLdac: begin
          if (tick) begin
            nLDacReg <= 1'b1;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : gCh
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        txData[i]  <= '0;
        rxData[i]  <= '0;
        txShift[i] <= '0;
        rxShift[i] <= '0;
      end else begin
        if (wrStrobe & ~busy & wTx & (wrAddr[5:2] == 4'(i))) begin
          txData[i] <= wrData[FRAME_BITS-1:0];
        end
        // Masked channels load zeros so their Mosi stays low for the whole frame.
        if (startSetup) txShift[i] <= chMask[i] ? txData[i] : '0;
        else if (shiftEn) txShift[i] <= txShift[i] << 1;
        if (sampleEn) rxShift[i] <= {rxShift[i][FRAME_BITS-2:0], Miso[i]};
        if (frameEnd & chMask[i]) rxData[i] <= rxShift[i];
      end
    end
    assign Mosi[i] = txShift[i][FRAME_BITS-1];
  end

  assign Sck           = sckReg;
  assign nCs           = nCsReg;
  assign nLDac         = nLDacReg;
  assign RamBusAck     = ackReg;
  assign RamBusDataOut = dataOutReg;

  assign unusedBits = ^{wrData, wrAddr[1:0], RamBusAddress[1:0]};

endmodule

// File: tb/tb_dm_spi_array_master.sv
// Directed self-checking bench for dm_spi_array_master (NCHAN=6, FRAME_BITS=24), Miso looped to Mosi.
module tb_dm_spi_array_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RamBusSel = 1'b0, RamBusWrnRd = 1'b0, RamBusLatch = 1'b0;
  logic [13:0] RamBusAddress = '0;
  logic [31:0] RamBusDataIn = '0;
  logic [31:0] RamBusDataOut;
  logic        RamBusAck;
  logic        Pps = 1'b0;
  logic        Sck, nLDac;
  logic [5:0]  Mosi, Miso, nCs;

  int checks = 0;
  int errors = 0;

  assign Miso = Mosi;

  always #5 clk = ~clk;

  dm_spi_array_master #(
    .NCHAN      (6),
    .FRAME_BITS (24),
    .ADDR_W     (14)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RamBusSel     (RamBusSel),
    .RamBusWrnRd   (RamBusWrnRd),
    .RamBusLatch   (RamBusLatch),
    .RamBusAddress (RamBusAddress),
    .RamBusDataIn  (RamBusDataIn),
    .RamBusDataOut (RamBusDataOut),
    .RamBusAck     (RamBusAck),
    .Pps           (Pps),
    .Sck           (Sck),
    .Mosi          (Mosi),
    .Miso          (Miso),
    .nCs           (nCs),
    .nLDac         (nLDac)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic busAccess(input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    logic got;
    got   = 1'b0;
    rdata = '0;
    @(posedge clk); #1;
    RamBusSel = 1'b1; RamBusLatch = 1'b1; RamBusWrnRd = wr;
    RamBusAddress = addr; RamBusDataIn = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (RamBusAck) begin
        got   = 1'b1;
        rdata = RamBusDataOut;
      end
    end
    RamBusSel = 1'b0; RamBusLatch = 1'b0;
    check("bus_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic busWrite(input logic [13:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    busAccess(1'b1, addr, wdata, dummy);
  endtask

  task automatic checkRead(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    busAccess(1'b0, addr, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic watchFrame(output int csLow, output int ldacLow, output int sckRises,
                            output int sckHighMax, output logic [5:0] csSeen,
                            output logic [5:0] mosiSeen);
    int   quiet, run;
    logic act, prevSck;
    csLow = 0; ldacLow = 0; sckRises = 0; sckHighMax = 0; csSeen = '0; mosiSeen = '0;
    quiet = 0; run = 0; act = 1'b0; prevSck = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (nCs != 6'h3F) csLow++;
      if (!nLDac) ldacLow++;
      if (Sck && !prevSck) sckRises++;
      run = Sck ? run + 1 : 0;
      if (run > sckHighMax) sckHighMax = run;
      prevSck  = Sck;
      csSeen   = csSeen | ~nCs;
      mosiSeen = mosiSeen | Mosi;
      if (nCs != 6'h3F || Sck || !nLDac) begin
        act   = 1'b1;
        quiet = 0;
      end else if (act) begin
        quiet++;
      end
      if (act && quiet >= 12) break;
    end
    check("frame_ended", {31'd0, act && quiet >= 12}, 32'd1);
  endtask

  int          csLow, ldacLow, sckRises, sckHighMax, lat;
  logic [5:0]  csSeen, mosiSeen;
  logic        sckSeen;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", {31'd0, Sck}, 32'd0);
    check("rst_ncs", {26'd0, nCs}, 32'h3F);
    check("rst_mosi", {26'd0, Mosi}, 32'd0);
    check("rst_nldac", {31'd0, nLDac}, 32'd1);
    check("rst_ack", {31'd0, RamBusAck}, 32'd0);
    check("rst_dout", RamBusDataOut, 32'd0);
    rst = 1'b0;
    checkRead("rst_status", 14'h004, 32'd0);
    checkRead("rst_ctrl", 14'h000, 32'd0);
    checkRead("rst_chmask", 14'h008, 32'd0);

    // Basic frame: all channels, DIV=0, LDAC_EN=1
    busWrite(14'h008, 32'h3F);
    for (int i = 0; i < 6; i++) busWrite(14'h100 + 14'(4 * i), 32'hA50000 + i);
    checkRead("tx3_readback", 14'h10C, 32'hA50003);
    busWrite(14'h000, 32'h3);
    watchFrame(csLow, ldacLow, sckRises, sckHighMax, csSeen, mosiSeen);
    check("basic_cs_low_cycles", csLow, 50);
    check("basic_ldac_cycles", ldacLow, 1);
    check("basic_frame_len", csLow + ldacLow, 51);
    check("basic_sck_rises", sckRises, 24);
    check("basic_sck_high", sckHighMax, 1);
    check("basic_cs_seen", {26'd0, csSeen}, 32'h3F);
    for (int i = 0; i < 6; i++) checkRead("basic_rx", 14'h200 + 14'(4 * i), 32'hA50000 + i);
    checkRead("basic_status", 14'h004, 32'h0001_0002);
    checkRead("unmapped_read", 14'h00C, 32'd0);

    // Divider and mask: DIV=3, channels 0 and 2
    busWrite(14'h100, 32'h5A5A5A);
    busWrite(14'h108, 32'h00FF0F);
    busWrite(14'h008, 32'h05);
    busWrite(14'h000, 32'h301);
    watchFrame(csLow, ldacLow, sckRises, sckHighMax, csSeen, mosiSeen);
    check("div_cs_low_cycles", csLow, 200);
    check("div_ldac_cycles", ldacLow, 0);
    check("div_sck_rises", sckRises, 24);
    check("div_sck_high", sckHighMax, 4);
    check("div_cs_seen", {26'd0, csSeen}, 32'h05);
    check("div_mosi_seen", {26'd0, mosiSeen}, 32'h05);
    checkRead("div_rx0", 14'h200, 32'h5A5A5A);
    checkRead("div_rx1_kept", 14'h204, 32'hA50001);
    checkRead("div_rx2", 14'h208, 32'h00FF0F);
    checkRead("div_status", 14'h004, 32'h0002_0002);

    // PPS trigger
    busWrite(14'h000, 32'h5);
    checkRead("pps_armed_status", 14'h004, 32'h0002_000B);
    sckSeen = 1'b0;
    csSeen  = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      sckSeen = sckSeen | Sck;
      csSeen  = csSeen | ~nCs;
    end
    check("pps_no_sck", {31'd0, sckSeen}, 32'd0);
    check("pps_no_cs", {26'd0, csSeen}, 32'd0);
    @(posedge clk); #1;
    Pps = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (nCs != 6'h3F) begin
        lat = c;
        break;
      end
    end
    check("pps_latency", lat, 3);
    watchFrame(csLow, ldacLow, sckRises, sckHighMax, csSeen, mosiSeen);
    checkRead("pps_status", 14'h004, 32'h0003_0002);
    checkRead("pps_rx0", 14'h200, 32'h5A5A5A);

    // Abort from ARM
    Pps = 1'b0;
    repeat (4) @(posedge clk);
    busWrite(14'h000, 32'h5);
    checkRead("abort_armed", 14'h004, 32'h0003_000B);
    busWrite(14'h000, 32'h0);
    checkRead("abort_status", 14'h004, 32'h0003_0002);
    @(posedge clk); #1;
    Pps = 1'b1;
    csSeen = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      csSeen = csSeen | ~nCs;
    end
    check("abort_no_frame", {26'd0, csSeen}, 32'd0);
    checkRead("abort_status_after_pps", 14'h004, 32'h0003_0002);
    Pps = 1'b0;

    // Busy protection
    busWrite(14'h004, 32'h6);
    checkRead("clear_status", 14'h004, 32'h0003_0000);
    busWrite(14'h100, 32'h654321);
    busWrite(14'h008, 32'h01);
    busWrite(14'h000, 32'h1);
    busWrite(14'h000, 32'h1);
    busWrite(14'h100, 32'h123456);
    repeat (150) @(posedge clk);
    checkRead("busy_status", 14'h004, 32'h0004_0006);
    checkRead("busy_rx0", 14'h200, 32'h654321);
    checkRead("busy_tx0_kept", 14'h100, 32'h654321);
    busWrite(14'h004, 32'h6);
    checkRead("busy_clear", 14'h004, 32'h0004_0000);

    // Counter wrap
    force dut.frameCnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frameCnt;
    checkRead("wrap_preset", 14'h004, 32'hFFFF_0000);
    busWrite(14'h000, 32'h1);
    repeat (80) @(posedge clk);
    checkRead("wrap_status", 14'h004, 32'h0000_0002);

    // Reset mid-frame
    busWrite(14'h008, 32'h3F);
    busWrite(14'h000, 32'h3);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_cs", {26'd0, nCs}, 32'h00);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ncs", {26'd0, nCs}, 32'h3F);
    check("midrst_sck", {31'd0, Sck}, 32'd0);
    check("midrst_nldac", {31'd0, nLDac}, 32'd1);
    check("midrst_mosi", {26'd0, Mosi}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkRead("midrst_status", 14'h004, 32'd0);
    checkRead("midrst_chmask", 14'h008, 32'd0);
    checkRead("midrst_rx0", 14'h200, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
